id_decode_stage: RTL and testbench
==================================

ID_DECODE_STAGE -- requirements
Module: id_decode_stage

Interface
REQ-001 Parameters SHALL be: NBITS 32, datapath width; NBITSJUMP 26, jump field width; REGS 5, register address width (2^REGS registers); INBITS 16, immediate width; TNBITS 2, extension-mode width; CNTBITS 16, stall-counter width.
REQ-002 Ports SHALL be: i_clk in 1 clock; i_reset in 1 asynchronous active-low reset; i_step in 1 pipeline advance enable.
REQ-003 Ports SHALL be: i_wb_regwrite in 1 writeback enable; i_wb_dir_rd in REGS writeback address; i_wb_write in NBITS writeback data.
REQ-004 Ports SHALL be: i_dir_rs, i_dir_rt, i_dir_rd in REGS decoded addresses; i_tx_dir_debug in REGS debug read address; i_id_valid in 1 instruction present in ID.
REQ-005 Ports SHALL be: i_if_id_jump in NBITSJUMP; i_id_expc4 in NBITS PC+4; i_id_inmediate in INBITS; i_rctrl_extensionmode in TNBITS; i_branch_eq, i_branch_ne in 1 branch type.
REQ-006 Ports SHALL be: i_ex_memread in 1 EX holds a load; i_ex_dir_rt in REGS load destination; i_flush in 1 squash ID/EX.
REQ-007 Ports SHALL be: o_stall out 1; o_branch_taken out 1; o_branch_target, o_id_jump, o_data_tx_debug out NBITS; o_stall_count out CNTBITS.
REQ-008 ID/EX outputs SHALL be: o_ex_valid out 1; o_ex_data_rs, o_ex_data_rt, o_ex_extension out NBITS; o_ex_dir_rs, o_ex_dir_rt, o_ex_dir_rd out REGS.

Function
REQ-009 Register file SHALL hold 2^REGS words of NBITS; register 0 SHALL always read 0 and never be written.
REQ-010 Write SHALL occur on rising i_clk when i_step=1, i_wb_regwrite=1, i_wb_dir_rd!=0.
REQ-011 Reads of rs, rt, debug SHALL be combinational with write-through bypass: same-cycle qualifying write to the read address returns i_wb_write.
REQ-012 Extension mode 0 SHALL sign-extend, 1 zero-extend, 2 place immediate in upper INBITS with lower bits zero, 3 output 0.
REQ-013 o_id_jump SHALL be {i_id_expc4[NBITS-1:NBITSJUMP+2], i_if_id_jump, 2'b00}, combinational.
REQ-014 o_branch_target SHALL be i_id_expc4 + (sign-extended immediate << 2), modulo 2^NBITS.
REQ-015 o_stall SHALL be 1 when i_id_valid and i_ex_memread and i_ex_dir_rt!=0 and i_ex_dir_rt equals i_dir_rs or i_dir_rt; combinational.
REQ-016 Branch compare SHALL use bypassed rs/rt; o_branch_taken = i_id_valid & !o_stall & ((i_branch_eq & rs==rt) | (i_branch_ne & rs!=rt)); both branch types set SHALL give 0.
REQ-017 ID/EX register SHALL update only on rising i_clk with i_step=1; i_step=0 SHALL hold all state.
REQ-018 Update priority SHALL be: i_flush -> o_ex_valid=0, other fields zero; else o_stall -> bubble identical to flush; else capture bypassed data, extension, addresses, o_ex_valid=i_id_valid.
REQ-019 o_stall_count SHALL increment on each stepped cycle where o_stall=1 and i_flush=0, and saturate at 2^CNTBITS-1.

Reset
REQ-020 i_reset=0 SHALL immediately clear all registers, all ID/EX outputs, o_ex_valid and o_stall_count to 0, independent of i_clk and i_step.
REQ-021 Reset asserted mid-stall or mid-write SHALL discard that operation; first stepped edge after release SHALL behave as from empty pipeline.

Verification
REQ-022 Write r5=0xDEADBEEF with step, read rs=5 same and next cycle -> 0xDEADBEEF both (bypass then stored); write r0=7 -> rs=0 reads 0.
REQ-023 i_ex_memread=1, i_ex_dir_rt=3, i_dir_rt=3, valid=1 -> o_stall=1, next o_ex_valid=0, o_stall_count 0->1; with i_ex_dir_rt=0 -> o_stall=0.
REQ-024 Immediate 0x8004, PC+4 0x00000100: mode0 -> 0xFFFF8004, mode1 -> 0x00008004, mode2 -> 0x80040000, branch target 0xFFFE0110.
REQ-025 r1=r2=9, i_branch_eq=1 -> o_branch_taken=1; i_branch_ne=1 instead -> 0; i_flush with valid instruction -> o_ex_valid=0 next edge.
REQ-026 Stall held 2^CNTBITS+3 stepped cycles -> o_stall_count stays all-ones; i_step=0 cycles -> no change; i_reset pulse low -> all outputs 0 at once.

Source files
------------

// File: rtl/id_decode_stage_if.sv
// id_decode_stage_if: signal bundle between the decode stage and its surroundings
interface id_decode_stage_if #(
  parameter int NBITS     = 32,
  parameter int NBITSJUMP = 26,
  parameter int REGS      = 5,
  parameter int INBITS    = 16,
  parameter int TNBITS    = 2,
  parameter int CNTBITS   = 16
);
  logic                 i_step;
  logic                 i_wb_regwrite;
  logic [REGS-1:0]      i_wb_dir_rd;
  logic [NBITS-1:0]     i_wb_write;
  logic [REGS-1:0]      i_dir_rs;
  logic [REGS-1:0]      i_dir_rt;
  logic [REGS-1:0]      i_dir_rd;
  logic [REGS-1:0]      i_tx_dir_debug;
  logic                 i_id_valid;
  logic [NBITSJUMP-1:0] i_if_id_jump;
  logic [NBITS-1:0]     i_id_expc4;
  logic [INBITS-1:0]    i_id_inmediate;
  logic [TNBITS-1:0]    i_rctrl_extensionmode;
  logic                 i_branch_eq;
  logic                 i_branch_ne;
  logic                 i_ex_memread;
  logic [REGS-1:0]      i_ex_dir_rt;
  logic                 i_flush;
  logic                 o_stall;
  logic                 o_branch_taken;
  logic [NBITS-1:0]     o_branch_target;
  logic [NBITS-1:0]     o_id_jump;
  logic [NBITS-1:0]     o_data_tx_debug;
  logic [CNTBITS-1:0]   o_stall_count;
  logic                 o_ex_valid;
  logic [NBITS-1:0]     o_ex_data_rs;
  logic [NBITS-1:0]     o_ex_data_rt;
  logic [NBITS-1:0]     o_ex_extension;
  logic [REGS-1:0]      o_ex_dir_rs;
  logic [REGS-1:0]      o_ex_dir_rt;
  logic [REGS-1:0]      o_ex_dir_rd;
  modport slave (
    input  i_step, i_wb_regwrite, i_wb_dir_rd, i_wb_write, i_dir_rs, i_dir_rt, i_dir_rd,
           i_tx_dir_debug, i_id_valid, i_if_id_jump, i_id_expc4, i_id_inmediate,
           i_rctrl_extensionmode, i_branch_eq, i_branch_ne, i_ex_memread, i_ex_dir_rt, i_flush,
    output o_stall, o_branch_taken, o_branch_target, o_id_jump, o_data_tx_debug, o_stall_count,
           o_ex_valid, o_ex_data_rs, o_ex_data_rt, o_ex_extension, o_ex_dir_rs, o_ex_dir_rt,
           o_ex_dir_rd
  );
  modport master (
    output i_step, i_wb_regwrite, i_wb_dir_rd, i_wb_write, i_dir_rs, i_dir_rt, i_dir_rd,
           i_tx_dir_debug, i_id_valid, i_if_id_jump, i_id_expc4, i_id_inmediate,
           i_rctrl_extensionmode, i_branch_eq, i_branch_ne, i_ex_memread, i_ex_dir_rt, i_flush,
    input  o_stall, o_branch_taken, o_branch_target, o_id_jump, o_data_tx_debug, o_stall_count,
           o_ex_valid, o_ex_data_rs, o_ex_data_rt, o_ex_extension, o_ex_dir_rs, o_ex_dir_rt,
           o_ex_dir_rd
  );
endinterface

// File: rtl/id_decode_stage.sv
// id_decode_stage: register file, immediate extension, branch/jump resolution, load-use stall and ID/EX register
module id_decode_stage #(
  parameter int NBITS     = 32,
  parameter int NBITSJUMP = 26,
  parameter int REGS      = 5,
  parameter int INBITS    = 16,
  parameter int TNBITS    = 2,
  parameter int CNTBITS   = 16
) (
  input logic i_clk,
  input logic i_reset,
  id_decode_stage_if.slave bus
);
  localparam int NREGS = 1 << REGS;
  logic [NBITS-1:0]   r_regs [NREGS];
  logic               r_ex_valid;
  logic [NBITS-1:0]   r_ex_data_rs, r_ex_data_rt, r_ex_extension;
  logic [REGS-1:0]    r_ex_dir_rs, r_ex_dir_rt, r_ex_dir_rd;
  logic [CNTBITS-1:0] r_stall_count;
  logic               w_wr, w_stall, w_bubble;
  logic [NBITS-1:0]   w_rs, w_rt, w_dbg, w_sext, w_ext;
  assign w_wr   = bus.i_step & bus.i_wb_regwrite & (bus.i_wb_dir_rd != '0);
  assign w_rs   = (w_wr && bus.i_wb_dir_rd == bus.i_dir_rs) ? bus.i_wb_write : r_regs[bus.i_dir_rs];
  assign w_rt   = (w_wr && bus.i_wb_dir_rd == bus.i_dir_rt) ? bus.i_wb_write : r_regs[bus.i_dir_rt];
  assign w_dbg  = (w_wr && bus.i_wb_dir_rd == bus.i_tx_dir_debug) ? bus.i_wb_write : r_regs[bus.i_tx_dir_debug];
  assign w_sext = {{(NBITS-INBITS){bus.i_id_inmediate[INBITS-1]}}, bus.i_id_inmediate};
  // immediate extension selected by the control unit's mode field
  always_comb
    w_ext = (bus.i_rctrl_extensionmode == TNBITS'(0)) ? w_sext :
            (bus.i_rctrl_extensionmode == TNBITS'(1)) ? {{(NBITS-INBITS){1'b0}}, bus.i_id_inmediate} :
            (bus.i_rctrl_extensionmode == TNBITS'(2)) ? {bus.i_id_inmediate, {(NBITS-INBITS){1'b0}}} :
            '0;
  assign w_stall  = bus.i_id_valid & bus.i_ex_memread & (bus.i_ex_dir_rt != '0) &
                    ((bus.i_ex_dir_rt == bus.i_dir_rs) | (bus.i_ex_dir_rt == bus.i_dir_rt));
  assign w_bubble = bus.i_flush | w_stall;
  assign bus.o_stall         = w_stall;
  assign bus.o_branch_taken  = bus.i_id_valid & ~w_stall & ~(bus.i_branch_eq & bus.i_branch_ne) &
                               ((bus.i_branch_eq & (w_rs == w_rt)) | (bus.i_branch_ne & (w_rs != w_rt)));
  assign bus.o_branch_target = bus.i_id_expc4 + (w_sext << 2);
  assign bus.o_id_jump       = {bus.i_id_expc4[NBITS-1:NBITSJUMP+2], bus.i_if_id_jump, 2'b00};
  assign bus.o_data_tx_debug = w_dbg;
  assign bus.o_stall_count   = r_stall_count;
  assign bus.o_ex_valid      = r_ex_valid;
  assign bus.o_ex_data_rs    = r_ex_data_rs;
  assign bus.o_ex_data_rt    = r_ex_data_rt;
  assign bus.o_ex_extension  = r_ex_extension;
  assign bus.o_ex_dir_rs     = r_ex_dir_rs;
  assign bus.o_ex_dir_rt     = r_ex_dir_rt;
  assign bus.o_ex_dir_rd     = r_ex_dir_rd;
  // register file write port; register 0 is never written so it stays zero
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset)
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    else if (w_wr)
      r_regs[bus.i_wb_dir_rd] <= bus.i_wb_write;
  // ID/EX pipeline register; flush and load-use stall both insert a zeroed bubble
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      r_ex_valid     <= 1'b0;
      r_ex_data_rs   <= '0;
      r_ex_data_rt   <= '0;
      r_ex_extension <= '0;
      r_ex_dir_rs    <= '0;
      r_ex_dir_rt    <= '0;
      r_ex_dir_rd    <= '0;
    end else if (bus.i_step) begin
      r_ex_valid     <= w_bubble ? 1'b0 : bus.i_id_valid;
      r_ex_data_rs   <= w_bubble ? '0 : w_rs;
      r_ex_data_rt   <= w_bubble ? '0 : w_rt;
      r_ex_extension <= w_bubble ? '0 : w_ext;
      r_ex_dir_rs    <= w_bubble ? '0 : bus.i_dir_rs;
      r_ex_dir_rt    <= w_bubble ? '0 : bus.i_dir_rt;
      r_ex_dir_rd    <= w_bubble ? '0 : bus.i_dir_rd;
    end
  // saturating count of stepped cycles lost to load-use stalls
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset)
      r_stall_count <= '0;
    else if (bus.i_step && w_stall && !bus.i_flush && r_stall_count != '1)
      r_stall_count <= r_stall_count + 1'b1;
endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: randomized and directed checks of id_decode_stage against a behavioural model
module tb_id_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  id_decode_stage_if bus();
  id_decode_stage dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));
  always #5 clk = ~clk;

  logic [31:0] ref_regs [32];
  logic        e_valid;
  logic [31:0] e_rs, e_rt, e_ext;
  logic [4:0]  e_drs, e_drt, e_drd;
  int          e_cnt;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (bus.i_step && bus.i_wb_regwrite && bus.i_wb_dir_rd != 0 && bus.i_wb_dir_rd == a) return bus.i_wb_write;
    return (a == 0) ? 32'd0 : ref_regs[a];
  endfunction

  function automatic logic [31:0] m_sext(input logic [15:0] imm);
    return (imm >= 16'h8000) ? 32'(imm) + 32'hFFFF0000 : 32'(imm);
  endfunction

  function automatic logic [31:0] m_ext(input logic [15:0] imm, input logic [1:0] mode);
    case (mode)
      2'd0: return m_sext(imm);
      2'd1: return 32'(imm);
      2'd2: return 32'(imm) * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_stall();
    return bus.i_id_valid && bus.i_ex_memread && bus.i_ex_dir_rt != 0 &&
           (bus.i_ex_dir_rt == bus.i_dir_rs || bus.i_ex_dir_rt == bus.i_dir_rt);
  endfunction

  function automatic logic m_taken();
    logic [31:0] a, b;
    a = m_read(bus.i_dir_rs);
    b = m_read(bus.i_dir_rt);
    if (!bus.i_id_valid || m_stall() || bus.i_branch_eq == bus.i_branch_ne) return 1'b0;
    return bus.i_branch_eq ? (a == b) : (a != b);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    {e_valid, e_rs, e_rt, e_ext, e_drs, e_drt, e_drd} = '0;
    e_cnt = 0;
  endtask

  task automatic model_edge();
    logic st;
    st = m_stall();
    if (bus.i_step) begin
      if (bus.i_flush || st) {e_valid, e_rs, e_rt, e_ext, e_drs, e_drt, e_drd} = '0;
      else begin
        e_valid = bus.i_id_valid;
        e_rs    = m_read(bus.i_dir_rs);
        e_rt    = m_read(bus.i_dir_rt);
        e_ext   = m_ext(bus.i_id_inmediate, bus.i_rctrl_extensionmode);
        e_drs   = bus.i_dir_rs;
        e_drt   = bus.i_dir_rt;
        e_drd   = bus.i_dir_rd;
      end
      if (st && !bus.i_flush && e_cnt < 65535) e_cnt++;
      if (bus.i_wb_regwrite && bus.i_wb_dir_rd != 0) ref_regs[bus.i_wb_dir_rd] = bus.i_wb_write;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_step = 1'b1; bus.i_wb_regwrite = 1'b0; bus.i_wb_dir_rd = '0; bus.i_wb_write = '0;
    bus.i_dir_rs = '0; bus.i_dir_rt = '0; bus.i_dir_rd = '0; bus.i_tx_dir_debug = '0;
    bus.i_id_valid = 1'b0; bus.i_if_id_jump = '0; bus.i_id_expc4 = '0; bus.i_id_inmediate = '0;
    bus.i_rctrl_extensionmode = '0; bus.i_branch_eq = 1'b0; bus.i_branch_ne = 1'b0;
    bus.i_ex_memread = 1'b0; bus.i_ex_dir_rt = '0; bus.i_flush = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({bus.o_ex_valid, bus.o_ex_data_rs, bus.o_ex_data_rt, bus.o_ex_extension, bus.o_ex_dir_rs,
         bus.o_ex_dir_rt, bus.o_ex_dir_rd, bus.o_stall_count, bus.o_stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_state ex_valid=%b rs=%h cnt=%h stall=%b expected all zero",
               bus.o_ex_valid, bus.o_ex_data_rs, bus.o_stall_count, bus.o_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_regfile();
    idle_inputs();
    bus.i_wb_regwrite = 1'b1; bus.i_wb_dir_rd = 5'd5; bus.i_wb_write = 32'hDEADBEEF;
    bus.i_dir_rs = 5'd5; bus.i_tx_dir_debug = 5'd5;
    #1;
    n_checks++;
    if (bus.o_data_tx_debug !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_r5 got %h expected DEADBEEF", bus.o_data_tx_debug);
    end
    tick();
    bus.i_wb_regwrite = 1'b0;
    #1;
    n_checks++;
    if (bus.o_data_tx_debug !== 32'hDEADBEEF || bus.o_ex_data_rs !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL stored_r5 dbg=%h ex_rs=%h expected DEADBEEF", bus.o_data_tx_debug, bus.o_ex_data_rs);
    end
    bus.i_wb_regwrite = 1'b1; bus.i_wb_dir_rd = 5'd0; bus.i_wb_write = 32'd7;
    bus.i_dir_rs = 5'd0; bus.i_tx_dir_debug = 5'd0;
    #1;
    n_checks++;
    if (bus.o_data_tx_debug !== 32'd0) begin
      n_fail++; $display("FAIL r0_bypass got %h expected 0", bus.o_data_tx_debug);
    end
    tick();
    bus.i_wb_regwrite = 1'b0;
    #1;
    n_checks++;
    if (bus.o_data_tx_debug !== 32'd0 || bus.o_ex_data_rs !== 32'd0) begin
      n_fail++; $display("FAIL r0_write dbg=%h ex_rs=%h expected 0", bus.o_data_tx_debug, bus.o_ex_data_rs);
    end
    for (int i = 0; i < 60; i++) begin
      bus.i_wb_regwrite = 1'($urandom_range(0, 1));
      bus.i_wb_dir_rd = 5'($urandom); bus.i_wb_write = $urandom;
      bus.i_tx_dir_debug = ($urandom_range(0, 2) == 0) ? bus.i_wb_dir_rd : 5'($urandom);
      #1;
      n_checks++;
      if (bus.o_data_tx_debug !== m_read(bus.i_tx_dir_debug)) begin
        n_fail++; $display("FAIL rand_read addr=%0d got %h expected %h", bus.i_tx_dir_debug, bus.o_data_tx_debug, m_read(bus.i_tx_dir_debug));
      end
      tick();
    end
    bus.i_wb_regwrite = 1'b0;
  endtask

  task automatic test_extension();
    logic [31:0] exp_ext [4];
    exp_ext[0] = 32'hFFFF8004; exp_ext[1] = 32'h00008004; exp_ext[2] = 32'h80040000; exp_ext[3] = 32'h0;
    idle_inputs();
    bus.i_id_inmediate = 16'h8004; bus.i_id_expc4 = 32'h00000100; bus.i_id_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.o_branch_target !== 32'hFFFE0110) begin
      n_fail++; $display("FAIL branch_target got %h expected FFFE0110", bus.o_branch_target);
    end
    for (int m = 0; m < 4; m++) begin
      bus.i_rctrl_extensionmode = 2'(m);
      tick();
      n_checks++;
      if (bus.o_ex_extension !== exp_ext[m]) begin
        n_fail++; $display("FAIL ext_mode%0d got %h expected %h", m, bus.o_ex_extension, exp_ext[m]);
      end
    end
    for (int i = 0; i < 30; i++) begin
      bus.i_id_inmediate = 16'($urandom); bus.i_id_expc4 = $urandom; bus.i_if_id_jump = 26'($urandom);
      bus.i_rctrl_extensionmode = 2'($urandom);
      #1;
      n_checks++;
      if (bus.o_branch_target !== bus.i_id_expc4 + m_sext(bus.i_id_inmediate) * 4 ||
          bus.o_id_jump !== (bus.i_id_expc4 & 32'hF0000000) + 32'(bus.i_if_id_jump) * 4) begin
        n_fail++; $display("FAIL target_jump tgt=%h jmp=%h", bus.o_branch_target, bus.o_id_jump);
      end
      tick();
      n_checks++;
      if (bus.o_ex_extension !== e_ext) begin
        n_fail++; $display("FAIL rand_ext got %h expected %h", bus.o_ex_extension, e_ext);
      end
    end
  endtask

  task automatic test_stall();
    test_reset();
    idle_inputs();
    bus.i_ex_memread = 1'b1; bus.i_ex_dir_rt = 5'd3; bus.i_dir_rt = 5'd3; bus.i_dir_rs = 5'd1; bus.i_id_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.o_stall !== 1'b1 || bus.o_stall_count !== 16'd0) begin
      n_fail++; $display("FAIL stall_set stall=%b cnt=%0d expected 1,0", bus.o_stall, bus.o_stall_count);
    end
    tick();
    n_checks++;
    if (bus.o_ex_valid !== 1'b0 || bus.o_stall_count !== 16'd1) begin
      n_fail++; $display("FAIL stall_bubble valid=%b cnt=%0d expected 0,1", bus.o_ex_valid, bus.o_stall_count);
    end
    bus.i_ex_dir_rt = 5'd0; bus.i_dir_rt = 5'd0;
    #1;
    n_checks++;
    if (bus.o_stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_r0 got %b expected 0", bus.o_stall);
    end
    tick();
  endtask

  task automatic test_branch();
    idle_inputs();
    bus.i_wb_regwrite = 1'b1; bus.i_wb_dir_rd = 5'd1; bus.i_wb_write = 32'd9;
    tick();
    bus.i_wb_dir_rd = 5'd2;
    tick();
    bus.i_wb_regwrite = 1'b0; bus.i_dir_rs = 5'd1; bus.i_dir_rt = 5'd2; bus.i_id_valid = 1'b1;
    bus.i_branch_eq = 1'b1;
    #1;
    n_checks++;
    if (bus.o_branch_taken !== 1'b1) begin
      n_fail++; $display("FAIL beq_taken got %b expected 1", bus.o_branch_taken);
    end
    bus.i_branch_eq = 1'b0; bus.i_branch_ne = 1'b1;
    #1;
    n_checks++;
    if (bus.o_branch_taken !== 1'b0) begin
      n_fail++; $display("FAIL bne_not_taken got %b expected 0", bus.o_branch_taken);
    end
    bus.i_branch_eq = 1'b1;
    #1;
    n_checks++;
    if (bus.o_branch_taken !== 1'b0) begin
      n_fail++; $display("FAIL both_types got %b expected 0", bus.o_branch_taken);
    end
    bus.i_branch_eq = 1'b0; bus.i_branch_ne = 1'b0; bus.i_flush = 1'b1;
    tick();
    n_checks++;
    if (bus.o_ex_valid !== 1'b0 || bus.o_ex_data_rs !== 32'd0) begin
      n_fail++; $display("FAIL flush valid=%b rs=%h expected 0,0", bus.o_ex_valid, bus.o_ex_data_rs);
    end
    bus.i_flush = 1'b0;
  endtask

  task automatic test_random_pipeline();
    for (int i = 0; i < 400; i++) begin
      bus.i_step = ($urandom_range(0, 3) != 0);
      bus.i_flush = ($urandom_range(0, 9) == 0);
      bus.i_wb_regwrite = 1'($urandom); bus.i_wb_dir_rd = 5'($urandom_range(0, 7)); bus.i_wb_write = $urandom;
      bus.i_dir_rs = 5'($urandom_range(0, 7)); bus.i_dir_rt = 5'($urandom_range(0, 7)); bus.i_dir_rd = 5'($urandom);
      bus.i_tx_dir_debug = 5'($urandom_range(0, 7)); bus.i_id_valid = 1'($urandom);
      bus.i_id_inmediate = 16'($urandom); bus.i_rctrl_extensionmode = 2'($urandom); bus.i_id_expc4 = $urandom;
      bus.i_branch_eq = 1'($urandom); bus.i_branch_ne = 1'($urandom);
      bus.i_ex_memread = 1'($urandom); bus.i_ex_dir_rt = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) bus.i_dir_rt = bus.i_dir_rs;
      #1;
      n_checks++;
      if ({bus.o_stall, bus.o_branch_taken, bus.o_data_tx_debug} !== {m_stall(), m_taken(), m_read(bus.i_tx_dir_debug)}) begin
        n_fail++;
        $display("FAIL rand_comb stall=%b taken=%b dbg=%h expected %b %b %h", bus.o_stall, bus.o_branch_taken,
                 bus.o_data_tx_debug, m_stall(), m_taken(), m_read(bus.i_tx_dir_debug));
      end
      tick();
      n_checks++;
      if ({bus.o_ex_valid, bus.o_ex_data_rs, bus.o_ex_data_rt, bus.o_ex_extension, bus.o_ex_dir_rs, bus.o_ex_dir_rt,
           bus.o_ex_dir_rd, bus.o_stall_count} !== {e_valid, e_rs, e_rt, e_ext, e_drs, e_drt, e_drd, 16'(e_cnt)}) begin
        n_fail++;
        $display("FAIL rand_idex got v=%b rs=%h rt=%h ext=%h cnt=%0d expected v=%b rs=%h rt=%h ext=%h cnt=%0d",
                 bus.o_ex_valid, bus.o_ex_data_rs, bus.o_ex_data_rt, bus.o_ex_extension, bus.o_stall_count,
                 e_valid, e_rs, e_rt, e_ext, e_cnt);
      end
    end
  endtask

  task automatic test_saturate_and_hold();
    idle_inputs();
    bus.i_ex_memread = 1'b1; bus.i_ex_dir_rt = 5'd3; bus.i_dir_rs = 5'd3; bus.i_id_valid = 1'b1;
    for (int i = 0; i < 65539; i++) tick();
    n_checks++;
    if (bus.o_stall_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL saturate got %h expected FFFF", bus.o_stall_count);
    end
    idle_inputs();
    bus.i_id_valid = 1'b1; bus.i_dir_rs = 5'd1; bus.i_dir_rd = 5'd7;
    tick();
    bus.i_step = 1'b0; bus.i_dir_rs = 5'd2; bus.i_dir_rd = 5'd4; bus.i_ex_memread = 1'b1; bus.i_ex_dir_rt = 5'd2;
    bus.i_wb_regwrite = 1'b1; bus.i_wb_dir_rd = 5'd6; bus.i_wb_write = 32'h55AA55AA;
    for (int i = 0; i < 5; i++) tick();
    bus.i_wb_regwrite = 1'b0; bus.i_tx_dir_debug = 5'd6;
    #1;
    n_checks++;
    if ({bus.o_ex_valid, bus.o_ex_dir_rs, bus.o_ex_dir_rd, bus.o_stall_count, bus.o_data_tx_debug} !==
        {1'b1, 5'd1, 5'd7, 16'hFFFF, ref_regs[6]}) begin
      n_fail++;
      $display("FAIL step_hold v=%b drs=%0d drd=%0d cnt=%h dbg=%h expected 1 1 7 ffff %h", bus.o_ex_valid,
               bus.o_ex_dir_rs, bus.o_ex_dir_rd, bus.o_stall_count, bus.o_data_tx_debug, ref_regs[6]);
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    bus.i_wb_regwrite = 1'b1; bus.i_wb_dir_rd = 5'd5; bus.i_wb_write = 32'h1234; bus.i_id_valid = 1'b1;
    bus.i_ex_memread = 1'b1; bus.i_ex_dir_rt = 5'd9; bus.i_dir_rs = 5'd9; bus.i_tx_dir_debug = 5'd1;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({bus.o_ex_valid, bus.o_ex_data_rs, bus.o_ex_data_rt, bus.o_ex_extension, bus.o_ex_dir_rs,
         bus.o_ex_dir_rt, bus.o_ex_dir_rd, bus.o_stall_count, bus.o_data_tx_debug} !== '0) begin
      n_fail++;
      $display("FAIL async_reset v=%b drs=%0d cnt=%h dbg=%h expected all zero", bus.o_ex_valid, bus.o_ex_dir_rs,
               bus.o_stall_count, bus.o_data_tx_debug);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    bus.i_tx_dir_debug = 5'd5; bus.i_id_valid = 1'b1; bus.i_dir_rs = 5'd5; bus.i_dir_rd = 5'd2;
    #1;
    n_checks++;
    if (bus.o_data_tx_debug !== 32'd0 || bus.o_stall_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_discard dbg=%h cnt=%h expected 0,0", bus.o_data_tx_debug, bus.o_stall_count);
    end
    tick();
    n_checks++;
    if ({bus.o_ex_valid, bus.o_ex_data_rs, bus.o_ex_dir_rd} !== {e_valid, e_rs, e_drd}) begin
      n_fail++; $display("FAIL post_reset v=%b rs=%h drd=%0d expected %b %h %0d", bus.o_ex_valid, bus.o_ex_data_rs,
                         bus.o_ex_dir_rd, e_valid, e_rs, e_drd);
    end
  endtask

  initial begin
    test_reset();
    test_regfile();
    test_extension();
    test_stall();
    test_branch();
    test_random_pipeline();
    test_saturate_and_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
